maxnet_controller: RTL
======================

// Module: maxnet_controller
// PURPOSE
//  Sequencer for the 4-neuron MaxNet winner-take-all datapath.
//  - On start: loads the four neuron inputs into the x and t registers.
//  - Then repeatedly commits PU/activation results back into t until the datapath reports a single survivor.
//  - Signals result_valid; the datapath's maximum_number output is then stable.
// PARAMETERS
//  PU_LAT   2   cycles from a t-register update until the activation outputs are valid (PU pipeline depth)
//  ITER_W   6   width of the iteration counter
//  MAX_ITER 31  iteration cap; used only when MAXNET_TIMEOUT_EN is defined; must be < 2**ITER_W
// PORTS
//  clk           in   1       rising-edge clock
//  rst           in   1       asynchronous, active-low reset (0 = reset)
//  start         in   1       request a new max search; sampled in IDLE or DONE only
//  dp_done       in   1       datapath done flag: at most one t register nonzero
//  ld_x          out  1       load enable for the x registers
//  ld_t          out  1       load enable for the t registers
//  sel_t         out  1       t-mux select: 1 = neuron inputs, 0 = activation outputs
//  busy          out  1       high in LOAD/CHECK/WAIT/UPDATE
//  result_valid  out  1       high in DONE
//  iter_count    out  ITER_W  number of UPDATE cycles in the current search
//  timeout_err   out  1       search ended by the iteration cap
// BEHAVIOUR
//  - Reset (rst=0, asynchronous): state=IDLE, iter_count=0, all outputs 0, effective immediately incl. mid-search.
//  - Moore FSM; all outputs decoded from registered state/counters. Per-state outputs:
//    IDLE    all outputs 0; start=1 -> LOAD.
//    LOAD    ld_x=ld_t=sel_t=1, busy=1, for 1 cycle; iter_count<=0, timeout_err<=0 -> CHECK.
//    CHECK   busy=1, 1 cycle. dp_done=1 -> DONE.
//            Else PU_LAT>0 -> WAIT with wait counter=PU_LAT-1; PU_LAT=0 -> UPDATE.
//    WAIT    busy=1; counts down; at 0 -> UPDATE. Stays exactly PU_LAT cycles.
//    UPDATE  ld_t=1, sel_t=0, busy=1, for 1 cycle; iter_count++ (saturates at all-ones) -> CHECK.
//    DONE    result_valid=1; iter_count and timeout_err held. start=1 -> LOAD; else stay.
//  - start during busy is ignored (no queuing). start held high in DONE restarts on every DONE visit.
//  - ld_x is asserted only in LOAD; x registers hold the original inputs for the output mux.
//  - sel_t is 0 in all states except LOAD.
//  - dp_done is ignored outside CHECK.
// CONFIGURATION
//  MAXNET_TIMEOUT_EN defined:
//    - In CHECK, if dp_done=0 and iter_count==MAX_ITER: -> DONE with timeout_err<=1.
//    - Cleared in LOAD.
//  MAXNET_TIMEOUT_EN undefined:
//    - No cap; iterates until dp_done.
//    - timeout_err is tied 0; the port is kept.
// STRUCTURE
//  - Shared package maxnet_pkg: state encoding localparams S_IDLE, S_LOAD, S_CHECK, S_WAIT, S_UPDATE, S_DONE (3-bit).
//    Shared by controller and bench monitors.
//  - One sub-module, maxnet_wait_counter: loadable down-counter with a zero flag; width $clog2(PU_LAT+1), minimum 1.
//  - FSM and iteration counter remain in maxnet_controller.
// TESTING  (cycle N = state during cycle N; start pulsed in cycle 0 from IDLE; PU_LAT=2 unless noted)
//  1. Already one-hot inputs (dp_done=1 from cycle 2):
//     LOAD c1 (ld_x=ld_t=sel_t=1), CHECK c2, DONE c3; result_valid=1, iter_count=0.
//  2. dp_done rises during the CHECK after the 3rd UPDATE:
//     ld_t=1/sel_t=0 at c5, c9, c13; CHECK c14; DONE c15; iter_count=3.
//  3. rst=0 during WAIT (c3): ld_t, busy and iter_count read 0 in the same cycle; after release, state IDLE.
//  4. start held 1 through the search:
//     - no second LOAD while busy;
//     - in DONE, LOAD follows next cycle, iter_count clears, result_valid drops.
//  5. MAXNET_TIMEOUT_EN, MAX_ITER=4, dp_done stuck 0: DONE after 4th UPDATE with timeout_err=1, iter_count=4.
//     Without the macro: a 5th UPDATE occurs and timeout_err stays 0.
//  6. PU_LAT=0, dp_done stuck 0: UPDATE every 2nd cycle (c3, c5, c7...); WAIT never entered.

Source files
------------

// File: rtl/maxnet_pkg.sv
// Shared definitions for the MaxNet winner-take-all sequencer.
// State encodings are exported as plain localparams so monitors can compare against them.
package maxnet_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_CHECK  = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_UPDATE = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE   = S_IDLE,
        ST_LOAD   = S_LOAD,
        ST_CHECK  = S_CHECK,
        ST_WAIT   = S_WAIT,
        ST_UPDATE = S_UPDATE,
        ST_DONE   = S_DONE
    } state_t;

    // Wait-counter width: enough to hold PU_LAT-1, never narrower than one bit.
    function automatic int cnt_width(input int lat);
        return (lat <= 1) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/maxnet_wait_counter.sv
// Loadable down-counter that paces the PU pipeline latency between t-register updates.
module maxnet_wait_counter
    import maxnet_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_q;

    // Load takes priority; decrement stops at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - W'(1);
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/maxnet_controller.sv
// Sequencer for the 4-neuron MaxNet datapath: load inputs, then commit PU results
// into t until the datapath reports a single survivor.
// Optional iteration cap enabled by defining MAXNET_TIMEOUT_EN.
//
//  state  | meaning
//  IDLE   | waiting for start
//  LOAD   | neuron inputs into x and t registers
//  CHECK  | look at dp_done (and the iteration cap)
//  WAIT   | PU pipeline settling, PU_LAT cycles
//  UPDATE | activation outputs committed into t
//  DONE   | result valid, waiting for a new start
module maxnet_controller
    import maxnet_pkg::*;
#(
    parameter int PU_LAT   = 2,
    parameter int ITER_W   = 6,
    parameter int MAX_ITER = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              dp_done,
    output logic              ld_x,
    output logic              ld_t,
    output logic              sel_t,
    output logic              busy,
    output logic              result_valid,
    output logic [ITER_W-1:0] iter_count,
    output logic              timeout_err
);

    localparam int CNT_W = cnt_width(PU_LAT);
    localparam logic [CNT_W-1:0] WAIT_INIT = (PU_LAT > 0) ? CNT_W'(PU_LAT - 1) : '0;
    localparam logic [ITER_W-1:0] ITER_SAT = '1;

    state_t state_q;
    state_t state_d;
    logic   wait_load;
    logic   wait_dec;
    logic   wait_zero;
    logic   timeout_hit;

    maxnet_wait_counter #(
        .W(CNT_W)
    ) u_wait_counter (
        .clk       (clk),
        .rst       (rst),
        .load      (wait_load),
        .load_value(WAIT_INIT),
        .dec       (wait_dec),
        .zero      (wait_zero)
    );

`ifdef MAXNET_TIMEOUT_EN
    assign timeout_hit = (iter_count == ITER_W'(MAX_ITER));

    // Timeout flag: cleared at the start of a search, set when the cap ends it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timeout_err <= 1'b0;
        end else if (state_q == ST_LOAD) begin
            timeout_err <= 1'b0;
        end else if ((state_q == ST_CHECK) && !dp_done && timeout_hit) begin
            timeout_err <= 1'b1;
        end
    end
`else
    logic [31:0] unused_max_iter;
    assign unused_max_iter = 32'(MAX_ITER);
    assign timeout_hit     = 1'b0;
    assign timeout_err     = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Iteration counter: cleared in LOAD, saturating increment per UPDATE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iter_count <= '0;
        end else if (state_q == ST_LOAD) begin
            iter_count <= '0;
        end else if ((state_q == ST_UPDATE) && (iter_count != ITER_SAT)) begin
            iter_count <= iter_count + ITER_W'(1);
        end
    end

    // Next-state and Moore output decode.
    always_comb begin
        state_d      = state_q;
        ld_x         = 1'b0;
        ld_t         = 1'b0;
        sel_t        = 1'b0;
        busy         = 1'b0;
        result_valid = 1'b0;
        wait_load    = 1'b0;
        wait_dec     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                ld_x    = 1'b1;
                ld_t    = 1'b1;
                sel_t   = 1'b1;
                busy    = 1'b1;
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                busy = 1'b1;
                if (dp_done || timeout_hit) begin
                    state_d = ST_DONE;
                end else if (PU_LAT > 0) begin
                    wait_load = 1'b1;
                    state_d   = ST_WAIT;
                end else begin
                    state_d = ST_UPDATE;
                end
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (wait_zero) state_d = ST_UPDATE;
                else           wait_dec = 1'b1;
            end
            ST_UPDATE: begin
                ld_t    = 1'b1;
                busy    = 1'b1;
                state_d = ST_CHECK;
            end
            ST_DONE: begin
                result_valid = 1'b1;
                if (start) state_d = ST_LOAD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
